// File: rtl/gate_alu32_pkg.sv
// Opcode encodings and datapath width shared by the ALU and its adder.
package gate_alu32_pkg;

   localparam int WIDTH = 32;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOR = 3'b101;
   localparam logic [2:0] OP_SLL = 3'b110;
   localparam logic [2:0] OP_SRL = 3'b111;

endpackage

// File: rtl/gate_adder32.sv
// Ripple-carry adder from gate-level full adders; purely combinational.
// Latency 0; no flow control.
import gate_alu32_pkg::*;

module gate_adder32 #(
   parameter int W = WIDTH
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   wire [W:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < W; i++) begin : g_fa
      wire p, g, t;
      xor u_p   (p, a[i], b[i]);
      xor u_s   (sum[i], p, c[i]);
      and u_g   (g, a[i], b[i]);
      and u_t   (t, p, c[i]);
      or  u_c   (c[i+1], g, t);
   end

   assign cout = c[W];

endmodule

// File: rtl/gate_alu32.sv
// Eight-function 32-bit integer ALU with one output register stage.
// Latency 1 cycle; no backpressure, a new operation is accepted every cycle.
import gate_alu32_pkg::*;

module gate_alu32 (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] In1,
   input  logic [WIDTH-1:0] In2,
   input  logic             CI,
   input  logic [2:0]       A,
   output logic [WIDTH-1:0] FinalOut,
   output logic             CO
);

   logic             is_sub;
   logic [WIDTH-1:0] add_b;
   logic             add_cin;
   logic [WIDTH-1:0] add_sum;
   logic             add_cout;
   logic [4:0]       shamt;
   logic [WIDTH-1:0] sll_v;
   logic [WIDTH-1:0] srl_v;
   logic [WIDTH-1:0] res;
   logic             res_co;

   // SUB reuses the adder as In1 + ~In2 + 1, so CO=1 means no borrow
   assign is_sub  = (A == OP_SUB);
   assign add_b   = is_sub ? ~In2 : In2;
   assign add_cin = is_sub ? 1'b1 : CI;

   gate_adder32 #(.W(WIDTH)) u_adder (
      .a    (In1),
      .b    (add_b),
      .cin  (add_cin),
      .sum  (add_sum),
      .cout (add_cout)
   );

   assign shamt = In2[4:0];

   // five binary-weighted mux stages per direction
   always_comb begin
      sll_v = In1;
      srl_v = In1;
      for (int s = 0; s < 5; s++) begin
         if (shamt[s]) begin
            sll_v = sll_v << (1 << s);
            srl_v = srl_v >> (1 << s);
         end
      end
   end

   always_comb begin
      res    = '0;
      res_co = 1'b0;
      case (A)
         OP_ADD:  begin res = add_sum; res_co = add_cout; end
         OP_SUB:  begin res = add_sum; res_co = add_cout; end
         OP_AND:  res = In1 & In2;
         OP_OR:   res = In1 | In2;
         OP_XOR:  res = In1 ^ In2;
         OP_NOR:  res = ~(In1 | In2);
         OP_SLL:  res = sll_v;
         OP_SRL:  res = srl_v;
         default: res = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         FinalOut <= '0;
         CO       <= 1'b0;
      end else begin
         FinalOut <= res;
         CO       <= res_co;
      end
   end

endmodule

// File: tb/tb_gate_alu32.sv
// Directed-vector bench for gate_alu32 with hand-computed expectations.
module tb_gate_alu32;

   logic        clk;
   logic        rst;
   logic [31:0] In1;
   logic [31:0] In2;
   logic        CI;
   logic [2:0]  A;
   logic [31:0] FinalOut;
   logic        CO;

   int total = 0;
   int bad   = 0;

   gate_alu32 dut (
      .clk      (clk),
      .rst      (rst),
      .In1      (In1),
      .In2      (In2),
      .CI       (CI),
      .A        (A),
      .FinalOut (FinalOut),
      .CO       (CO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got co=%b out=%h, expected co=%b out=%h",
                  tag, got[32], got[31:0], exp[32], exp[31:0]);
      end
   endtask

   // drive between edges, then sample just after the next rising edge
   task automatic apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic ci);
      @(negedge clk);
      A   = op;
      In1 = a;
      In2 = b;
      CI  = ci;
      @(posedge clk);
      #1;
   endtask

   logic [31:0] sweep_exp [8];
   string       sweep_tag [8];

   initial begin
      sweep_exp = '{32'hA0104012, 32'hA010400E, 32'h00000000, 32'hA0104012,
                    32'hA0104012, 32'h5FEFBFED, 32'h80410040, 32'h28041004};
      sweep_tag = '{"sweep_add", "sweep_sub", "sweep_and", "sweep_or",
                    "sweep_xor", "sweep_nor", "sweep_sll", "sweep_srl"};

      rst = 1'b0;
      A   = 3'b000;
      In1 = 32'h0;
      In2 = 32'h0;
      CI  = 1'b0;

      // load a nonzero result, then reset asynchronously between edges
      apply(3'b000, 32'h12345678, 32'h11111111, 1'b1);
      chk("preload_add", {CO, FinalOut}, {1'b0, 32'h2345678A});
      @(negedge clk);
      A   = 3'b101;
      In1 = 32'hDEADBEEF;
      In2 = 32'h0BADF00D;
      rst = 1'b1;
      #1;
      chk("reset_immediate", {CO, FinalOut}, 33'h0);
      @(posedge clk);
      #1;
      chk("reset_held", {CO, FinalOut}, 33'h0);

      // release: nothing valid until the edge after deassertion
      @(negedge clk);
      rst = 1'b0;
      A   = 3'b000;
      In1 = 32'h00000010;
      In2 = 32'h00000020;
      CI  = 1'b0;
      #1;
      chk("release_before_edge", {CO, FinalOut}, 33'h0);
      @(posedge clk);
      #1;
      chk("release_first_result", {CO, FinalOut}, {1'b0, 32'h00000030});

      // opcode sweep, each opcode held for two cycles
      for (int op = 0; op < 8; op++) begin
         apply(op[2:0], 32'hA0104010, 32'h00000002, 1'b0);
         @(posedge clk);
         #1;
         chk(sweep_tag[op], {CO, FinalOut}, {(op == 1), sweep_exp[op]});
      end

      // carry and borrow boundaries
      apply(3'b000, 32'hFFFFFFFF, 32'h00000000, 1'b1);
      chk("add_carry_ci1", {CO, FinalOut}, {1'b1, 32'h00000000});
      apply(3'b000, 32'hFFFFFFFF, 32'h00000000, 1'b0);
      chk("add_nocarry_ci0", {CO, FinalOut}, {1'b0, 32'hFFFFFFFF});
      apply(3'b000, 32'hFFFFFFFF, 32'h00000001, 1'b0);
      chk("add_wrap", {CO, FinalOut}, {1'b1, 32'h00000000});
      apply(3'b001, 32'h00000000, 32'h00000001, 1'b1);
      chk("sub_borrow", {CO, FinalOut}, {1'b0, 32'hFFFFFFFF});
      apply(3'b001, 32'h00000005, 32'h00000005, 1'b0);
      chk("sub_equal", {CO, FinalOut}, {1'b1, 32'h00000000});

      // shift amount bounds; upper In2 bits must be ignored
      apply(3'b110, 32'h80000001, 32'h00000020, 1'b0);
      chk("sll_amt0", {CO, FinalOut}, {1'b0, 32'h80000001});
      apply(3'b110, 32'h80000001, 32'h0000001F, 1'b0);
      chk("sll_31", {CO, FinalOut}, {1'b0, 32'h80000000});
      apply(3'b111, 32'h80000001, 32'h0000001F, 1'b0);
      chk("srl_31", {CO, FinalOut}, {1'b0, 32'h00000001});
      apply(3'b111, 32'hF0000000, 32'hFFFFFFE4, 1'b1);
      chk("srl_4_hi_ignored", {CO, FinalOut}, {1'b0, 32'h0F000000});

      // async reset mid-stream during ADD, held across two edges
      apply(3'b000, 32'h00000003, 32'h00000004, 1'b0);
      chk("midstream_add", {CO, FinalOut}, {1'b0, 32'h00000007});
      @(negedge clk);
      In1 = 32'hFFFFFFFF;
      In2 = 32'hFFFFFFFF;
      CI  = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      chk("midstream_rst_now", {CO, FinalOut}, 33'h0);
      @(posedge clk);
      #1;
      chk("midstream_rst_edge1", {CO, FinalOut}, 33'h0);
      @(posedge clk);
      #1;
      chk("midstream_rst_edge2", {CO, FinalOut}, 33'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("midstream_after_release", {CO, FinalOut}, {1'b1, 32'hFFFFFFFF});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
